// File: rtl/sort_ram_dp.sv
// Dual-port working memory for the sorting datapath: port A read/write, port B read-only,
// both with registered reads, plus a sequential clear engine and an atomic two-location swap.
//
// state  | meaning
// -------+-------------------------------------------------------------
// CLEAR  | writing 0 to mem[ptr], one location per cycle; busy=1
// IDLE   | accepting clr_req > swp_req > a_we; busy=0
// SWP_W0 | writing tmp1 into mem[swp_a0]; busy=1
// SWP_W1 | writing tmp0 into mem[swp_a1]; busy=1, swp_done follows
module sort_ram_dp #(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    input  logic                  swp_req,
    input  logic [ADDR_WIDTH-1:0] swp_addr0,
    input  logic [ADDR_WIDTH-1:0] swp_addr1,
    output logic                  swp_done
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SWP_W0 = 2'd2,
        ST_SWP_W1 = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] swp_a0;
    logic [ADDR_WIDTH-1:0] swp_a1;
    logic [DATA_WIDTH-1:0] tmp0;
    logic [DATA_WIDTH-1:0] tmp1;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  clr_accept;
    logic                  swp_accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: begin
                if (ptr == PTR_LAST) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    next_state = ST_CLEAR;
                end else if (swp_req) begin
                    next_state = ST_SWP_W0;
                end
            end
            ST_SWP_W0: next_state = ST_SWP_W1;
            ST_SWP_W1: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // All memory writes funnel through one port; the FSM picks the source.
    always_comb begin
        busy       = 1'b1;
        mem_we     = 1'b0;
        mem_waddr  = a_addr;
        mem_wdata  = a_din;
        clr_accept = 1'b0;
        swp_accept = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = '0;
            end
            ST_IDLE: begin
                busy       = 1'b0;
                clr_accept = clr_req;
                swp_accept = swp_req && !clr_req;
                mem_we     = a_we && !clr_req && !swp_req;
            end
            ST_SWP_W0: begin
                mem_we    = 1'b1;
                mem_waddr = swp_a0;
                mem_wdata = tmp1;
            end
            ST_SWP_W1: begin
                mem_we    = 1'b1;
                mem_waddr = swp_a1;
                mem_wdata = tmp0;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Gating on rst keeps a reset edge from landing half of an in-flight swap.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_dout   <= '0;
            b_dout   <= '0;
            swp_done <= 1'b0;
            ptr      <= '0;
        end else begin
            a_dout   <= mem[a_addr];
            b_dout   <= mem[b_addr];
            swp_done <= (state == ST_SWP_W1);
            if (state == ST_CLEAR) begin
                ptr <= ptr + ADDR_WIDTH'(1);
            end else if (clr_accept) begin
                ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (swp_accept) begin
            swp_a0 <= swp_addr0;
            swp_a1 <= swp_addr1;
            tmp0   <= mem[swp_addr0];
            tmp1   <= mem[swp_addr1];
        end
    end

endmodule

// File: tb/tb_sort_ram_dp.sv
// Directed bench for sort_ram_dp: reset clear, read-first latency, swaps, priority, reset abort.
module tb_sort_ram_dp;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        busy;
    logic        a_we;
    logic [2:0]  a_addr;
    logic [15:0] a_din;
    logic [15:0] a_dout;
    logic [2:0]  b_addr;
    logic [15:0] b_dout;
    logic        swp_req;
    logic [2:0]  swp_addr0;
    logic [2:0]  swp_addr1;
    logic        swp_done;

    int total;
    int bad;

    sort_ram_dp #(
        .ADDR_WIDTH   (3),
        .DATA_WIDTH   (16),
        .INIT_ON_RESET(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_dout   (a_dout),
        .b_addr   (b_addr),
        .b_dout   (b_dout),
        .swp_req  (swp_req),
        .swp_addr0(swp_addr0),
        .swp_addr1(swp_addr1),
        .swp_done (swp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        a_we   = 1'b1;
        a_addr = addr;
        a_din  = data;
        step();
        a_we   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        a_addr = addr;
        b_addr = addr;
        step();
        chk({tag, "_a"}, 32'(a_dout), 32'(exp));
        chk({tag, "_b"}, 32'(b_dout), 32'(exp));
    endtask

    task automatic clear_window(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(swp_done), 32'd0);
            step();
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic start_swap(input logic [2:0] s0, input logic [2:0] s1);
        swp_req   = 1'b1;
        swp_addr0 = s0;
        swp_addr1 = s1;
        step();
        swp_req   = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        clr_req   = 1'b0;
        a_we      = 1'b0;
        a_addr    = '0;
        a_din     = '0;
        b_addr    = '0;
        swp_req   = 1'b0;
        swp_addr0 = '0;
        swp_addr1 = '0;

        // reset held for two edges
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_a_dout", 32'(a_dout), 32'd0);
        chk("rst_b_dout", 32'(b_dout), 32'd0);
        chk("rst_done", 32'(swp_done), 32'd0);
        rst = 1'b1;
        clear_window("init_clr");
        for (int i = 0; i < 8; i++) begin
            a_addr = 3'(i);
            b_addr = 3'(7 - i);
            step();
            chk("init_zero_a", 32'(a_dout), 32'd0);
            chk("init_zero_b", 32'(b_dout), 32'd0);
        end

        // read-first: same-edge write invisible, visible on the next read
        a_we   = 1'b1;
        a_addr = 3'd3;
        b_addr = 3'd3;
        a_din  = 16'hA5A5;
        step();
        a_we   = 1'b0;
        chk("rf_old_a", 32'(a_dout), 32'h0000);
        chk("rf_old_b", 32'(b_dout), 32'h0000);
        step();
        chk("rf_new_a", 32'(a_dout), 32'hA5A5);
        chk("rf_new_b", 32'(b_dout), 32'hA5A5);

        // swap 1<->6 with a dropped write to addr 2 while busy
        wr(3'd1, 16'h0011);
        wr(3'd6, 16'h0066);
        start_swap(3'd1, 3'd6);
        a_we   = 1'b1;
        a_addr = 3'd2;
        a_din  = 16'hBEEF;
        chk("swp_busy1", 32'(busy), 32'd1);
        chk("swp_nodone1", 32'(swp_done), 32'd0);
        step();
        chk("swp_busy2", 32'(busy), 32'd1);
        chk("swp_nodone2", 32'(swp_done), 32'd0);
        step();
        a_we = 1'b0;
        chk("swp_free", 32'(busy), 32'd0);
        chk("swp_done", 32'(swp_done), 32'd1);
        step();
        chk("swp_done_pulse", 32'(swp_done), 32'd0);
        rd("swp_m1", 3'd1, 16'h0066);
        rd("swp_m6", 3'd6, 16'h0011);
        rd("swp_drop_m2", 3'd2, 16'h0000);

        // same-address swap
        wr(3'd4, 16'h1234);
        start_swap(3'd4, 3'd4);
        step();
        step();
        chk("same_done", 32'(swp_done), 32'd1);
        rd("same_m4", 3'd4, 16'h1234);

        // clr_req beats swp_req
        clr_req   = 1'b1;
        swp_req   = 1'b1;
        swp_addr0 = 3'd3;
        swp_addr1 = 3'd4;
        step();
        clr_req = 1'b0;
        swp_req = 1'b0;
        clear_window("prio_clr");
        chk("prio_nodone", 32'(swp_done), 32'd0);
        rd("prio_m3", 3'd3, 16'h0000);
        rd("prio_m4", 3'd4, 16'h0000);

        // reset during SWP_W0 aborts the swap and reruns the clear
        wr(3'd0, 16'hAAAA);
        wr(3'd7, 16'h7777);
        start_swap(3'd0, 3'd7);
        chk("abort_in_w0", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        chk("abort_rst_done", 32'(swp_done), 32'd0);
        rst = 1'b1;
        clear_window("abort_clr");
        for (int i = 0; i < 8; i++) begin
            rd("abort_zero", 3'(i), 16'h0000);
        end

        // back-to-back swaps: second accepted in the swp_done cycle of the first
        wr(3'd0, 16'h1000);
        wr(3'd1, 16'h1001);
        wr(3'd2, 16'h1002);
        wr(3'd3, 16'h1003);
        start_swap(3'd2, 3'd3);
        step();
        step();
        chk("b2b_done1", 32'(swp_done), 32'd1);
        start_swap(3'd0, 3'd1);
        chk("b2b_accept", 32'(busy), 32'd1);
        step();
        step();
        chk("b2b_done2", 32'(swp_done), 32'd1);
        rd("b2b_m0", 3'd0, 16'h1001);
        rd("b2b_m1", 3'd1, 16'h1000);
        rd("b2b_m2", 3'd2, 16'h1003);
        rd("b2b_m3", 3'd3, 16'h1002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_ram_dp.md
Name: sort_ram_dp

Overview:
- Parametrised dual-port working memory for the sorting datapath; successor to the single-port combinational-read RAM.
- Port A is read/write and port B is read-only, both with registered (1-cycle) reads, so the sorter can fetch two operands per cycle.
- Adds a scalable sequential clear engine, replacing the one-cycle clear of all locations.
- Adds an atomic swap command that exchanges two locations without sorter intervention.

Parameters:
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH locations.
- DATA_WIDTH, 16, bits per location.
- INIT_ON_RESET, 1, 1 = run the clear engine after reset; 0 = go straight to IDLE with contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; takes effect at a clk edge where rst=0.
- clr_req  in  1  request a full clear; accepted only when busy=0.
- busy  out  1  high during CLEAR or swap; writes and commands are not accepted.
- a_we  in  1  port A write enable.
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  registered read of mem[a_addr].
- b_addr  in  ADDR_WIDTH  port B address.
- b_dout  out  DATA_WIDTH  registered read of mem[b_addr].
- swp_req  in  1  request swap of mem[swp_addr0] and mem[swp_addr1]; accepted only when busy=0.
- swp_addr0  in  ADDR_WIDTH  first swap address, sampled on acceptance.
- swp_addr1  in  ADDR_WIDTH  second swap address, sampled on acceptance.
- swp_done  out  1  one-cycle pulse when a swap completes.

Behaviour:
- States are CLEAR, IDLE, SWP_W0 and SWP_W1. Only one internal write to the memory occurs per cycle.
- Reset (rst=0 at an edge):
  - a_dout=0, b_dout=0, swp_done=0, clear pointer=0.
  - State = CLEAR with busy=1 if INIT_ON_RESET=1; otherwise state = IDLE with busy=0.
  - Reset aborts any clear or swap in progress; a partial swap result is not completed.
- CLEAR:
  - Each edge with rst=1 writes 0 to mem[ptr] and increments ptr.
  - The edge that writes location DEPTH-1 moves to IDLE and wraps ptr to 0.
  - busy is 0 in the cycle after that edge, so busy stays high for exactly DEPTH cycles after rst rises.
  - a_we, clr_req and swp_req are ignored.
- Reads:
  - On every edge in every state (rst=1): a_dout<=mem[a_addr] and b_dout<=mem[b_addr].
  - Reads are read-first: a same-edge write to that address is not visible until the next read.
  - During CLEAR, reads return partially cleared contents.
- IDLE command priority is clr_req > swp_req > a_we:
  - clr_req=1: enter CLEAR with ptr=0. Any a_we or swp_req in that cycle is dropped.
  - swp_req=1 (clr_req=0): latch the addresses, tmp0<=mem[swp_addr0], tmp1<=mem[swp_addr1], then go to SWP_W0. A same-cycle a_we is dropped.
  - a_we=1 alone: mem[a_addr]<=a_din.
- SWP_W0: mem[addr0]<=tmp1, then go to SWP_W1.
- SWP_W1:
  - mem[addr1]<=tmp0, then go to IDLE.
  - swp_done=1 for the following single cycle, which is also the first cycle with busy=0.
- Swap latency: accept edge E0, write edges E1 and E2; swp_done is high in the cycle after E2.
- Swap with addr0==addr1 runs the full sequence; contents are unchanged and swp_done still pulses.
- busy=1 in SWP_W0 and SWP_W1. a_we, clr_req and swp_req are ignored there; reads are still serviced.
- A new swp_req asserted in the swp_done cycle is accepted; back-to-back swaps therefore run one every 3 cycles.
- Width rules:
  - Addresses are full-range with no out-of-range case.
  - The clear pointer is ADDR_WIDTH bits wide and detects the terminal count at DEPTH-1.

Test Plan:
- Reset clear: hold rst=0 for 2 edges, release with INIT_ON_RESET=1 (DEPTH=8) -> busy high for exactly 8 cycles, then low; every address reads 0 one cycle after its address is applied.
- Write/read latency and read-first: write 16'hA5A5 to addr 3 with a_addr=3 and b_addr=3 on the same edge -> that edge's a_dout and b_dout show the old value 0; the next edge shows 16'hA5A5 on both ports.
- Swap: mem[1]=16'h0011, mem[6]=16'h0066, pulse swp_req(1,6) -> busy high for 2 cycles and swp_done pulses on the 3rd cycle; afterwards mem[1]=16'h0066 and mem[6]=16'h0011. An a_we to addr 2 issued during busy is dropped, so mem[2] is unchanged.
- Same-address swap and priority: swp_req(4,4) -> contents unchanged and swp_done pulses. clr_req and swp_req together in IDLE -> clear wins, busy high 8 cycles, no swp_done.
- Reset mid-operation: assert rst=0 during SWP_W0 of swap(0,7) -> swp_done never pulses, the clear engine reruns, and all locations are 0 afterwards.
- Back-to-back swaps: issue swp_req(0,1) in the swp_done cycle of swap(2,3) -> the second swap is accepted immediately and both exchanges are correct.
